// File: rtl/nibble_serial_sub_ctrl.sv
// Nibble-serial WIDTH-bit subtractor: one 4-bit subtractor is reused once per clock,
// LSB nibble first, and the borrow is carried between nibbles in a register.

module parallel_subtractor_4bit (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       bi,
  output logic [3:0] diff,
  output logic       bo
);
  logic [4:0] full;

  // Bit 4 of the 5-bit difference is set exactly when x < y + bi.
  assign full = {1'b0, x} - {1'b0, y} - {4'b0000, bi};
  assign diff = full[3:0];
  assign bo   = full[4];
endmodule

module nibble_serial_sub_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             zero,
  output logic             busy
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] d_reg;
  logic             borrow_reg;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [3:0]       nib_d;
  logic             nib_bo;

  parallel_subtractor_4bit u_sub (
    .x    (nib_a),
    .y    (nib_b),
    .bi   (borrow_reg),
    .diff (nib_d),
    .bo   (nib_bo)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_valid) state_next = RUN;
        else             state_next = IDLE;
      end
      RUN: begin
        if (count == LAST) state_next = DONE;
        else               state_next = RUN;
      end
      DONE: begin
        if (res_ready) state_next = IDLE;
        else           state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Select the operand nibbles addressed by the current count.
  always_comb begin
    nib_a = 4'h0;
    nib_b = 4'h0;
    for (int i = 0; i < NIB; i++) begin
      nib_a = (count == CW'(i)) ? a_reg[4*i +: 4] : nib_a;
      nib_b = (count == CW'(i)) ? b_reg[4*i +: 4] : nib_b;
    end
  end

  // Operand capture, per-nibble result write-back and borrow chaining.
  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      d_reg      <= '0;
      borrow_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_reg      <= a;
            b_reg      <= b;
            borrow_reg <= bin;
            count      <= '0;
          end
        end
        RUN: begin
          for (int i = 0; i < NIB; i++) begin
            d_reg[4*i +: 4] <= (count == CW'(i)) ? nib_d : d_reg[4*i +: 4];
          end
          borrow_reg <= nib_bo;
          // Count saturates at the last nibble so it never addresses stale data.
          if (count != LAST) count <= count + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign start_ready = (state == IDLE);
  assign res_valid   = (state == DONE);
  assign busy        = (state != IDLE);
  assign d           = d_reg;
  assign bout        = borrow_reg;
  assign zero        = (state == DONE) && (d_reg == '0);
endmodule
